fwd_hazard_unit: RTL and testbench

- Control-side counterpart of the EX1 operand forwarding muxes. It produces the forward_a/forward_b selects those muxes consume, and the pipeline stall, bubble and flush controls.
- Keeps an internal shadow pipeline of destination tags (EX1, EX2, WB) driven from ID-stage decode fields.
- Computes forwarding decisions in ID and registers them so they line up with the instruction when it reaches EX1.
- Sits beside the ID/EX pipeline register in the 5-stage IF-ID-EX1-EX2-WB datapath.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fwd_src_resolve.sv | 46 ++++
 rtl/fwd_hazard_unit.sv | 130 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: forward-select encodings, the shadow
// destination-tag record and small helpers used by the hazard logic.
package cpu_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_EX2     = 2'b10;

  // Wide enough for up to 32 GPRs; narrower register addresses are zero-extended.
  localparam int TAG_RD_W = 5;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

  function automatic logic tag_hit(input tag_t t, input logic [TAG_RD_W-1:0] src);
    return t.valid && t.reg_write && (t.rd == src);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/fwd_src_resolve.sv
// Per-operand producer search over the shadow tags, youngest first:
// yields the next EX1 forward select, the ID write-back bypass and a load-use hit.
module fwd_src_resolve
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter bit ZERO_REG   = 1'b1
) (
  input  tag_t                  ex1_tag,
  input  tag_t                  ex2_tag,
  input  tag_t                  wb_tag,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  uses_src,
  output logic [1:0]            next_sel,
  output logic                  bypass,
  output logic                  load_use
);

  logic [TAG_RD_W-1:0] src_ext;
  logic                src_live;
  logic                hit_ex1, hit_ex2, hit_wb;

  assign src_ext  = TAG_RD_W'(src);
  assign src_live = uses_src && !(ZERO_REG && (src == '0));
  assign hit_ex1  = src_live && tag_hit(ex1_tag, src_ext);
  assign hit_ex2  = src_live && tag_hit(ex2_tag, src_ext);
  assign hit_wb   = src_live && tag_hit(wb_tag, src_ext);

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    next_sel = FWD_REGFILE;
    bypass   = 1'b0;
    load_use = 1'b0;
    if (hit_ex1) begin
      if (ex1_tag.mem_read) load_use = 1'b1;
      else                  next_sel = FWD_EX2;
    end else if (hit_ex2) begin
      next_sel = FWD_WB;
    end else if (hit_wb) begin
      // Producer retires at this edge and the reg file has no write-through.
      bypass = 1'b1;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and stall/bubble/flush control for the 5-stage pipeline.
// Optional saturating event counters are built when HAZARD_STATS_EN is defined.
module fwd_hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_taken,
  input  logic                  mem_stall,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  id_bypass_a,
  output logic                  id_bypass_b,
  output logic                  stall_id,
  output logic                  bubble_ex1,
  output logic                  flush_id
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]           stat_stall_cnt,
  output logic [15:0]           stat_fwd_cnt,
  output logic [15:0]           stat_flush_cnt
`endif
);

  tag_t       ex1_tag, ex2_tag, wb_tag, id_tag;
  logic [1:0] sel_a, sel_b, next_fwd_a, next_fwd_b;
  logic       byp_a, byp_b, lu_a, lu_b, load_use, kill_id;

  fwd_src_resolve #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_res_a (
    .ex1_tag (ex1_tag),
    .ex2_tag (ex2_tag),
    .wb_tag  (wb_tag),
    .src     (id_rs1),
    .uses_src(id_valid && id_uses_rs1),
    .next_sel(sel_a),
    .bypass  (byp_a),
    .load_use(lu_a)
  );

  fwd_src_resolve #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_res_b (
    .ex1_tag (ex1_tag),
    .ex2_tag (ex2_tag),
    .wb_tag  (wb_tag),
    .src     (id_rs2),
    .uses_src(id_valid && id_uses_rs2),
    .next_sel(sel_b),
    .bypass  (byp_b),
    .load_use(lu_b)
  );

  assign load_use = lu_a || lu_b;

  // A memory wait freezes everything; otherwise a taken branch beats a load-use stall.
  always_comb begin
    stall_id    = 1'b0;
    bubble_ex1  = 1'b0;
    flush_id    = 1'b0;
    id_bypass_a = 1'b0;
    id_bypass_b = 1'b0;
    if (mem_stall) begin
      stall_id = 1'b1;
    end else begin
      flush_id    = branch_taken;
      bubble_ex1  = branch_taken || load_use;
      stall_id    = load_use && !branch_taken;
      id_bypass_a = byp_a;
      id_bypass_b = byp_b;
    end
  end

  assign kill_id    = bubble_ex1 || !id_valid;
  assign next_fwd_a = kill_id ? FWD_REGFILE : sel_a;
  assign next_fwd_b = kill_id ? FWD_REGFILE : sel_b;

  always_comb begin
    id_tag = TAG_NONE;
    if (!kill_id) begin
      id_tag = '{valid: 1'b1, rd: TAG_RD_W'(id_rd),
                 reg_write: id_reg_write, mem_read: id_mem_read};
    end
  end

  // NOTE: state registers use non-blocking assignments so the whole shift
  // (ex1 -> ex2 -> wb) samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex1_tag   <= TAG_NONE;
      ex2_tag   <= TAG_NONE;
      wb_tag    <= TAG_NONE;
      forward_a <= FWD_REGFILE;
      forward_b <= FWD_REGFILE;
    end else if (!mem_stall) begin
      wb_tag    <= ex2_tag;
      ex2_tag   <= ex1_tag;
      ex1_tag   <= id_tag;
      forward_a <= next_fwd_a;
      forward_b <= next_fwd_b;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cnt <= '0;
      stat_fwd_cnt   <= '0;
      stat_flush_cnt <= '0;
    end else if (!mem_stall) begin
      // Outside a memory wait, stall_id can only come from a load-use hazard.
      if (stall_id)
        stat_stall_cnt <= sat_inc16(stat_stall_cnt);
      if ((next_fwd_a != FWD_REGFILE) || (next_fwd_b != FWD_REGFILE))
        stat_fwd_cnt <= sat_inc16(stat_fwd_cnt);
      if (branch_taken)
        stat_flush_cnt <= sat_inc16(stat_flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: in-flight instruction model compared every cycle,
// directed hazard scenarios with literal expectations, then random traffic.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       branch_taken, mem_stall;
  logic [1:0] forward_a, forward_b;
  logic       id_bypass_a, id_bypass_b, stall_id, bubble_ex1, flush_id;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_ADDR_W(4), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .forward_a(forward_a), .forward_b(forward_b),
    .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b),
    .stall_id(stall_id), .bubble_ex1(bubble_ex1), .flush_id(flush_id)
  );

  // Model: the instructions occupying EX1, EX2, WB (index 0, 1, 2).
  typedef struct { bit v; int rd; bit rw; bit ld; } slot_t;
  slot_t pipe [3];
  int    m_fa, m_fb, n_fa, n_fb;
  bit    n_kill, e_stall, e_bubble, e_flush, e_byp_a, e_byp_b;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, rd: 0, rw: 0, ld: 0};
    m_fa = 0;
    m_fb = 0;
  endfunction

  // Youngest in-flight writer of src decides what the operand needs.
  function automatic void resolve(input int src, input bit uses,
                                  output int sel, output bit byp, output bit lu);
    int who = -1;
    sel = 0; byp = 0; lu = 0;
    if (!id_valid || !uses || src == 0) return;
    for (int i = 0; i < 3; i++)
      if (who < 0 && pipe[i].v && pipe[i].rw && pipe[i].rd == src) who = i;
    if (who == 0) begin
      if (pipe[0].ld) lu = 1; else sel = 2;
    end else if (who == 1) sel = 1;
    else if (who == 2) byp = 1;
  endfunction

  task automatic model_compare();
    int sa, sb;
    bit ba, bb, la, lb, lu;
    resolve(int'(id_rs1), id_uses_rs1, sa, ba, la);
    resolve(int'(id_rs2), id_uses_rs2, sb, bb, lb);
    lu       = la || lb;
    e_flush  = !mem_stall && branch_taken;
    e_bubble = !mem_stall && (lu || branch_taken);
    e_stall  = mem_stall || (lu && !branch_taken);
    e_byp_a  = !mem_stall && ba;
    e_byp_b  = !mem_stall && bb;
    n_kill   = e_bubble || !id_valid;
    n_fa     = n_kill ? 0 : sa;
    n_fb     = n_kill ? 0 : sb;
    check("forward_a",   32'(forward_a),   m_fa);
    check("forward_b",   32'(forward_b),   m_fb);
    check("id_bypass_a", 32'(id_bypass_a), int'(e_byp_a));
    check("id_bypass_b", 32'(id_bypass_b), int'(e_byp_b));
    check("stall_id",    32'(stall_id),    int'(e_stall));
    check("bubble_ex1",  32'(bubble_ex1),  int'(e_bubble));
    check("flush_id",    32'(flush_id),    int'(e_flush));
  endtask

  task automatic drive(input bit v, input int rd, input bit rw, input bit ld,
                       input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit br, input bit ms);
    @(negedge clk);
    id_valid = v;      id_rd = 4'(rd);     id_reg_write = rw; id_mem_read = ld;
    id_rs1 = 4'(rs1);  id_uses_rs1 = u1;   id_rs2 = 4'(rs2);  id_uses_rs2 = u2;
    branch_taken = br; mem_stall = ms;
    #1;
    model_compare();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && !mem_stall) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = n_kill ? '{v: 0, rd: 0, rw: 0, ld: 0}
                       : '{v: 1, rd: int'(id_rd), rw: id_reg_write, ld: id_mem_read};
      m_fa = n_fa;
      m_fb = n_fb;
    end
  endtask

  task automatic nop();    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic drain();  repeat (3) begin nop(); tick(); end endtask

  initial begin
    bit v, rw, ld, u1, u2;
    int rd, rs1, rs2;

    rst = 1'b1;
    id_valid = 0; id_rd = 0; id_reg_write = 0; id_mem_read = 0;
    id_rs1 = 0; id_uses_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
    branch_taken = 0; mem_stall = 0;
    model_reset();
    #12;
    check("reset forward_a", 32'(forward_a), 0);
    check("reset forward_b", 32'(forward_b), 0);
    check("reset stall_id",  32'(stall_id),  0);
    @(negedge clk) rst = 1'b0;

    // ADD r3 ; ADD r4,r3,r1 -> EX2 forward on rs1, no stall
    drive(1, 3, 1, 0, 1, 1, 2, 1, 0, 0); tick();
    drive(1, 4, 1, 0, 3, 1, 1, 1, 0, 0);
    check("alu-alu no stall", 32'(stall_id), 0); tick();
    nop(); check("alu-alu forward_a", 32'(forward_a), 2); tick();
    drain();

    // ADD r3 ; NOP ; SUB r5,r2,r3 -> WB-path forward on rs2
    drive(1, 3, 1, 0, 1, 1, 2, 1, 0, 0); tick();
    nop(); tick();
    drive(1, 5, 1, 0, 2, 1, 3, 1, 0, 0); tick();
    nop(); check("gap1 forward_b", 32'(forward_b), 1); tick();
    drain();

    // ADD r3 ; NOP ; NOP ; OR r6,r3,r3 -> ID bypass on both, EX1 select 00
    drive(1, 3, 1, 0, 1, 1, 2, 1, 0, 0); tick();
    nop(); tick(); nop(); tick();
    drive(1, 6, 1, 0, 3, 1, 3, 1, 0, 0);
    check("gap2 bypass_a", 32'(id_bypass_a), 1);
    check("gap2 bypass_b", 32'(id_bypass_b), 1); tick();
    nop(); check("gap2 forward_a", 32'(forward_a), 0); tick();
    drain();

    // LW r7 ; ADD r8,r7,r7 -> one stall cycle, then WB-path forward on both
    drive(1, 7, 1, 1, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 8, 1, 0, 7, 1, 7, 1, 0, 0);
    check("load-use stall",  32'(stall_id),   1);
    check("load-use bubble", 32'(bubble_ex1), 1); tick();
    drive(1, 8, 1, 0, 7, 1, 7, 1, 0, 0);
    check("load-use released", 32'(stall_id), 0); tick();
    nop();
    check("load-use forward_a", 32'(forward_a), 1);
    check("load-use forward_b", 32'(forward_b), 1); tick();
    drain();

    // Same pair with a taken branch in the stall cycle: flush wins
    drive(1, 7, 1, 1, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 8, 1, 0, 7, 1, 7, 1, 1, 0);
    check("branch flush_id", 32'(flush_id), 1);
    check("branch stall_id", 32'(stall_id), 0); tick();
    nop(); check("flushed not in EX1", 32'(forward_a), 0); tick();
    drain();

    // r0 is hardwired zero: never forwarded, never bypassed
    drive(1, 0, 1, 0, 1, 1, 2, 1, 0, 0); tick();
    drive(1, 9, 1, 0, 0, 1, 0, 1, 0, 0);
    check("r0 bypass_a", 32'(id_bypass_a), 0); tick();
    nop(); check("r0 forward_a", 32'(forward_a), 0); tick();
    drain();

    // mem_stall for 3 cycles while EX1 holds a forwarded instruction
    drive(1, 3, 1, 0, 1, 1, 2, 1, 0, 0); tick();
    drive(1, 4, 1, 0, 3, 1, 1, 1, 0, 0); tick();
    repeat (3) begin
      drive(1, 6, 1, 0, 3, 1, 3, 1, 0, 1);
      check("memstall forward_a", 32'(forward_a), 2);
      check("memstall stall_id",  32'(stall_id),  1); tick();
    end
    drive(1, 6, 1, 0, 3, 1, 3, 1, 0, 0); tick();
    nop(); check("after memstall forward_b", 32'(forward_b), 1); tick();
    drain();

    // Reset asserted in the middle of a load-use stall
    drive(1, 3, 1, 0, 1, 1, 2, 1, 0, 0); tick();
    drive(1, 7, 1, 1, 3, 1, 0, 0, 0, 0); tick();
    drive(1, 8, 1, 0, 7, 1, 7, 1, 0, 0);
    check("pre-reset stall_id", 32'(stall_id), 1);
    #1 rst = 1'b1;
    #1;
    check("async rst forward_a",  32'(forward_a),  0);
    check("async rst stall_id",   32'(stall_id),   0);
    check("async rst bubble_ex1", 32'(bubble_ex1), 0);
    check("async rst flush_id",   32'(flush_id),   0);
    check("async rst bypass_a",   32'(id_bypass_a), 0);
    id_valid = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Random traffic over a few registers; ID holds while stalled
    v = 0; rd = 0; rw = 0; ld = 0; rs1 = 0; u1 = 0; rs2 = 0; u2 = 0;
    for (int n = 0; n < 600; n++) begin
      if (!e_stall || n == 0) begin
        v   = ($urandom_range(0, 99) < 85);
        rd  = int'($urandom_range(0, 5));
        rw  = ($urandom_range(0, 99) < 80);
        ld  = ($urandom_range(0, 99) < 30);
        rs1 = int'($urandom_range(0, 5));
        rs2 = int'($urandom_range(0, 5));
        u1  = ($urandom_range(0, 99) < 85);
        u2  = ($urandom_range(0, 99) < 70);
      end
      drive(v, rd, rw, ld, rs1, u1, rs2, u2,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
